// File: rtl/inst_loader_pkg.sv
// Shared definitions for the byte-stream instruction loader.
//   - state_t        : loader FSM states
//   - BYTE_W         : stream byte width
//   - HDR_FULL_DEPTH : header value that means "fill the whole address space"
//   - rsvd_mask()    : high-byte bits that must be zero for a given INST_W
// Optional feature macro: INST_LOADER_CHECKSUM_EN (used by inst_loader.sv).
package inst_loader_pkg;

  localparam int BYTE_W = 8;

  // A header of zero requests 2^ADDR_W words.
  localparam logic [BYTE_W-1:0] HDR_FULL_DEPTH = '0;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_CHK  = 3'd3,
    ST_FIN  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // Bits of the high byte above the instruction's top bit are reserved.
  function automatic logic [BYTE_W-1:0] rsvd_mask(input int inst_w);
    logic [BYTE_W-1:0] m;
    m = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (i >= inst_w - BYTE_W) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/inst_loader_word_asm.sv
// inst_word_asm: assembles one instruction from a low and a high stream byte.
// Ports:
//   CLK       clock (posedge)
//   start     synchronous active-high reset
//   lo_load   latch byte_in as the low byte
//   hi_load   pack byte_in with the latched low byte into word
//   byte_in   stream byte
//   word      registered instruction word (updated only on a clean high byte)
//   rsvd_err  combinational: byte_in has nonzero reserved bits
module inst_word_asm
  import inst_loader_pkg::*;
#(
  parameter int INST_W = 10
) (
  input  logic              CLK,
  input  logic              start,
  input  logic              lo_load,
  input  logic              hi_load,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [INST_W-1:0] word,
  output logic              rsvd_err
);

  localparam logic [BYTE_W-1:0] RSVD_MASK = rsvd_mask(INST_W);

  logic [BYTE_W-1:0] lo_reg;
  logic [INST_W-1:0] word_reg;
  logic [BYTE_W-1:0] rsvd_bits;

  for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_rsvd
    assign rsvd_bits[gi] = byte_in[gi] & RSVD_MASK[gi];
  end

  assign rsvd_err = |rsvd_bits;

  always_ff @(posedge CLK) begin
    if (start) begin
      lo_reg   <= '0;
      word_reg <= '0;
    end else begin
      if (lo_load) lo_reg <= byte_in;
      // A rejected high byte must not disturb the last good word on wr_data.
      if (hi_load && !rsvd_err) word_reg <= {byte_in[INST_W-BYTE_W-1:0], lo_reg};
    end
  end

  assign word = word_reg;

endmodule

// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader writing sequential instructions
// into instruction RAM and holding the CPU until the image is complete.
// Stream: header N (word count, 0 = 2^ADDR_W), then per word LO, HI bytes,
// then (with INST_LOADER_CHECKSUM_EN) one XOR checksum byte.
// Ports:
//   CLK           clock (posedge)
//   start         synchronous active-high reset
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   wr_en         RAM write strobe (one cycle per word)
//   wr_addr       RAM write address
//   wr_data       RAM write data
//   cpu_hold      high until the image is loaded
//   done          image loaded (sticky)
//   error         framing/format error (sticky)
//   words_loaded  number of words written
// Optional feature macro: INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_W    = 10,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remain_reg;
  logic [CNT_W-1:0]  words_reg;
  logic              wr_en_reg;
  logic              xfer;
  logic              rsvd_err;
  logic              hi_ok;
  logic              last_word;
  logic [CNT_W-1:0]  hdr_count;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_reg;
  logic              csum_ok;
  assign csum_ok = (in_data == csum_reg);
`endif

  assign xfer      = in_valid && in_ready;
  assign hi_ok     = xfer && (state_reg == ST_HI) && !rsvd_err;
  assign last_word = (remain_reg == CNT_W'(1));
  assign hdr_count = (in_data == HDR_FULL_DEPTH) ? FULL_DEPTH : CNT_W'(in_data);

  inst_word_asm #(.INST_W(INST_W)) u_word_asm (
    .CLK      (CLK),
    .start    (start),
    .lo_load  (xfer && (state_reg == ST_LO)),
    .hi_load  (xfer && (state_reg == ST_HI)),
    .byte_in  (in_data),
    .word     (wr_data),
    .rsvd_err (rsvd_err)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (start) state_reg <= ST_HDR;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR: if (xfer) state_next = ST_LO;
      ST_LO:  if (xfer) state_next = ST_HI;
      ST_HI: begin
        if (xfer) begin
          if (rsvd_err)        state_next = ST_ERR;
          else if (!last_word) state_next = ST_LO;
`ifdef INST_LOADER_CHECKSUM_EN
          else                 state_next = ST_CHK;
`else
          else                 state_next = ST_FIN;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHK: if (xfer) state_next = csum_ok ? ST_FIN : ST_ERR;
`endif
      ST_FIN:  state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_reg)
      ST_HDR, ST_LO, ST_HI, ST_CHK: in_ready = !start;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word counters, address, write strobe.
  always_ff @(posedge CLK) begin
    if (start) begin
      addr_reg   <= BASE;
      remain_reg <= '0;
      words_reg  <= '0;
      wr_en_reg  <= 1'b0;
    end else begin
      wr_en_reg <= hi_ok;
      if (xfer && (state_reg == ST_HDR)) remain_reg <= hdr_count;
      if (hi_ok) begin
        remain_reg <= remain_reg - CNT_W'(1);
        // Counted on the same edge that raises wr_en so both appear together.
        words_reg  <= words_reg + CNT_W'(1);
      end
      // The address advances after the strobe so wr_addr is stable during it.
      if (wr_en_reg) addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // Running XOR over header and instruction bytes; the checksum byte itself
  // is only compared, never folded in.
  always_ff @(posedge CLK) begin
    if (start) begin
      csum_reg <= '0;
    end else if (xfer) begin
      case (state_reg)
        ST_HDR:       csum_reg <= in_data;
        ST_LO, ST_HI: csum_reg <= csum_reg ^ in_data;
        default:      ;
      endcase
    end
  end
`endif

  assign wr_en        = wr_en_reg;
  assign wr_addr      = addr_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: a scoreboard queue holds the RAM
// writes expected from the driven stream and is drained by a write monitor.
module tb_inst_loader;

  logic       CLK = 1'b0;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [9:0] wr_data;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [8:0] words_loaded;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct {
    logic [7:0] addr;
    logic [9:0] data;
    logic [8:0] words;
  } wr_exp_t;

  wr_exp_t    sb[$];
  logic [7:0] tb_csum;

  always #5 CLK = ~CLK;

  inst_loader dut (
    .CLK          (CLK),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("wr_words", 32'(words_loaded), 32'(e.words));
        $display("write addr=%0d data=0x%03h words=%0d", wr_addr, wr_data, words_loaded);
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge CLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    start   = 1'b0;
    tb_csum = 8'h00;
  endtask

  // Offers one byte and returns 1 ns after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    #1;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge CLK);
      #1;
      tb_csum = tb_csum ^ b;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [9:0] w, input logic [8:0] words);
    wr_exp_t e;
    e.addr  = addr;
    e.data  = w;
    e.words = words;
    send_byte(w[7:0]);
    sb.push_back(e);
    send_byte({6'b0, w[9:8]});
  endtask

  // Ends the stream: sends the checksum byte when that feature is built in.
  task automatic end_stream();
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = tb_csum;
    send_byte(c);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tb_csum  = 8'h00;

    // Reset state
    @(posedge CLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(negedge CLK);
    start = 1'b0;
    #1;
    check("hdr_in_ready", 32'(in_ready), 32'd1);

    // Two-word image
    send_byte(8'h02);
    send_word(8'd0, 10'h134, 9'd1);
    send_word(8'd1, 10'h3FF, 9'd2);
    end_stream();
    check("fin_done", 32'(done), 32'd0);
    @(posedge CLK);
    #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd2);
    check("t1_in_ready", 32'(in_ready), 32'd0);

    // Byte offered while DONE is never taken
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      @(negedge CLK);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_sticky", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    check("done_words", 32'(words_loaded), 32'd2);

    // Reserved bit set in the high byte
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h04);
    check("rsvd_error", 32'(error), 32'd1);
    check("rsvd_in_ready", 32'(in_ready), 32'd0);
    check("rsvd_cpu_hold", 32'(cpu_hold), 32'd1);
    idle(3);
    check("rsvd_error_sticky", 32'(error), 32'd1);
    check("rsvd_done", 32'(done), 32'd0);
    check("rsvd_words", 32'(words_loaded), 32'd0);

    // Full-depth image (header 0) with idle gaps between bytes
    do_reset();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [9:0] w;
      w = {2'($urandom_range(0, 3)), 8'($urandom)};
      idle(1);
      send_word(8'(i), w, 9'(i + 1));
    end
    idle(1);
    end_stream();
    @(posedge CLK);
    #1;
    check("full_done", 32'(done), 32'd1);
    check("full_words", 32'(words_loaded), 32'd256);
    check("full_addr_wrap", 32'(wr_addr), 32'd0);

    // Reset in the middle of a load
    do_reset();
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) send_word(8'(i), 10'(10'h100 + i), 9'(i + 1));
    send_byte(8'h55);
    @(negedge CLK);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge CLK);
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge CLK);
    start    = 1'b0;
    in_valid = 1'b0;
    tb_csum  = 8'h00;
    send_byte(8'h01);
    send_word(8'd0, 10'h2A5, 9'd1);
    end_stream();
    @(posedge CLK);
    #1;
    check("reload_done", 32'(done), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
    // Explicit checksum vectors: good then bad
    do_reset();
    send_byte(8'h01);
    send_word(8'd0, 10'h212, 9'd1);
    send_byte(8'h11);
    @(posedge CLK);
    #1;
    check("csum_ok_done", 32'(done), 32'd1);
    check("csum_ok_error", 32'(error), 32'd0);

    do_reset();
    send_byte(8'h01);
    send_word(8'd0, 10'h212, 9'd1);
    send_byte(8'h10);
    @(posedge CLK);
    #1;
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
